// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// CPU control-unit port (C) and the debug/program-loader port (D).
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata        CPU request (level, held until cpu_ack)
//   cpu_ack, cpu_rdata           one-cycle completion pulse, registered read data
//   dbg_req/we/addr/wdata        debug request (level, held until dbg_ack)
//   dbg_ack, dbg_rdata           one-cycle completion pulse, registered read data
//   cpu_halted                   control unit is halted: debug port wins ties
//   mem_en/we/addr/wdata         memory strobe and payload, active in ACCESS only
//   mem_rdata                    memory read data, valid one cycle after mem_en
//   cpu_gnt, dbg_gnt             owner indication during ACCESS and RESP
//   busy                         arbiter is not idle
//   cpu_xfer_cnt, dbg_xfer_cnt   saturating transfer counters
//                                (present only with MEM_ARB_STATS_EN defined)
//
// Transaction: IDLE (arbitrate) -> ACCESS (strobe memory) -> RESP (ack,
// capture read data on exit) -> IDLE. Minimum 3 cycles per transaction.
// Ack, grant and memory outputs decode directly from the state register so
// that reset removes them asynchronously.

module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              cpu_halted,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_gnt,
    output logic              dbg_gnt,
    output logic              busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [7:0]        cpu_xfer_cnt,
    output logic [7:0]        dbg_xfer_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_e;

    state_e            state_q, state_d;
    port_e             sel_q, sel_d;
    port_e             last_gnt_q, last_gnt_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
`ifdef MEM_ARB_STATS_EN
    logic [7:0]        cpu_cnt_q, cpu_cnt_d;
    logic [7:0]        dbg_cnt_q, dbg_cnt_d;
`endif

    // State and data registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= PORT_C;
            last_gnt_q  <= PORT_D;
            wr_q        <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
`ifdef MEM_ARB_STATS_EN
            cpu_cnt_q   <= '0;
            dbg_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_gnt_q  <= last_gnt_d;
            wr_q        <= wr_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
`ifdef MEM_ARB_STATS_EN
            cpu_cnt_q   <= cpu_cnt_d;
            dbg_cnt_q   <= dbg_cnt_d;
`endif
        end
    end

    // Next-state, arbitration and output decode
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_gnt_d  = last_gnt_q;
        wr_d        = wr_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
`ifdef MEM_ARB_STATS_EN
        cpu_cnt_d   = cpu_cnt_q;
        dbg_cnt_d   = dbg_cnt_q;
`endif
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        cpu_ack     = 1'b0;
        dbg_ack     = 1'b0;
        cpu_gnt     = 1'b0;
        dbg_gnt     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req && dbg_req) begin
                    // Halted CPU yields to the loader; otherwise round robin.
                    if (cpu_halted) begin
                        sel_d = PORT_D;
                    end else begin
                        sel_d = (last_gnt_q == PORT_C) ? PORT_D : PORT_C;
                    end
                    state_d = ST_ACCESS;
                end else if (cpu_req) begin
                    sel_d   = PORT_C;
                    state_d = ST_ACCESS;
                end else if (dbg_req) begin
                    sel_d   = PORT_D;
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                mem_en = 1'b1;
                if (sel_q == PORT_D) begin
                    dbg_gnt   = 1'b1;
                    mem_we    = dbg_we;
                    mem_addr  = dbg_addr;
                    mem_wdata = dbg_wdata;
                end else begin
                    cpu_gnt   = 1'b1;
                    mem_we    = cpu_we;
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                end
                // Remember the direction the memory actually saw; the
                // requester may drop req (and change we) during RESP.
                wr_d    = mem_we;
                state_d = ST_RESP;
            end

            ST_RESP: begin
                if (sel_q == PORT_D) begin
                    dbg_gnt = 1'b1;
                    dbg_ack = 1'b1;
                    if (!wr_q) begin
                        dbg_rdata_d = mem_rdata;
                    end
`ifdef MEM_ARB_STATS_EN
                    if (dbg_cnt_q != 8'hFF) begin
                        dbg_cnt_d = dbg_cnt_q + 8'd1;
                    end
`endif
                end else begin
                    cpu_gnt = 1'b1;
                    cpu_ack = 1'b1;
                    if (!wr_q) begin
                        cpu_rdata_d = mem_rdata;
                    end
`ifdef MEM_ARB_STATS_EN
                    if (cpu_cnt_q != 8'hFF) begin
                        cpu_cnt_d = cpu_cnt_q + 8'd1;
                    end
`endif
                end
                last_gnt_d = sel_q;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef MEM_ARB_STATS_EN
    assign cpu_xfer_cnt = cpu_cnt_q;
    assign dbg_xfer_cnt = dbg_cnt_q;
`endif

endmodule
